// File: rtl/local_injection_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_SRC flit sources onto one router
// local input port, choosing a free downstream VC per packet and rewriting each flit's vcid.
package local_injection_arbiter_pkg;
  localparam int unsigned VC_NUM = 2;
  localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [VC_W-1:0]   vcid;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module local_injection_arbiter
  import local_injection_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  flit_t               src_data_i [NUM_SRC],
  input  logic [NUM_SRC-1:0]  src_valid_i,
  output logic [NUM_SRC-1:0]  src_ready_o,
  output flit_t               data_o,
  output logic                is_valid_o,
  input  logic [VC_NUM-1:0]   is_on_off_i,
  input  logic [VC_NUM-1:0]   is_allocatable_i,
  output logic [NUM_SRC-1:0]  grant_o,
  output logic [CNT_W-1:0]    pkt_count_o,
  output logic                error_o
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  typedef enum logic {StIdle, StSend} state_e;

  state_e             state_q;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [SRC_W-1:0]   owner_q;
  logic [VC_W-1:0]    cur_vc_q;
  logic [NUM_SRC-1:0] grant_q;
  flit_t              data_q;
  logic               valid_q;
  logic [CNT_W-1:0]   pkt_count_q;
  logic               error_q;

  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic               vc_found;
  logic [VC_W-1:0]    free_vc;
  logic [SRC_W-1:0]   sel_idx;
  flit_t              sel_flit;
  flit_t              out_flit;
  logic               xfer;

  // Modular increment that also works for non-power-of-two NUM_SRC.
  function automatic logic [SRC_W-1:0] wrap_add(logic [SRC_W-1:0] a, int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    return SRC_W'(s % NUM_SRC);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!win_found && src_valid_i[wrap_add(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    vc_found = 1'b0;
    free_vc  = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (!vc_found && is_allocatable_i[v] && is_on_off_i[v]) begin
        vc_found = 1'b1;
        free_vc  = VC_W'(v);
      end
    end
  end

  assign sel_idx = (state_q == StIdle) ? win_idx : owner_q;

  always_comb begin
    sel_flit      = src_data_i[sel_idx];
    out_flit      = sel_flit;
    out_flit.vcid = (state_q == StIdle) ? free_vc : cur_vc_q;
  end

  // Stray BODY/TAIL in idle are always consumed so a broken source cannot block the port.
  always_comb begin
    src_ready_o = '0;
    if (rst) begin
      if (state_q == StIdle) begin
        if (win_found) begin
          case (sel_flit.flit_label)
            HEAD, HEADTAIL: src_ready_o[win_idx] = vc_found;
            default:        src_ready_o[win_idx] = 1'b1;
          endcase
        end
      end else begin
        src_ready_o[owner_q] = is_on_off_i[cur_vc_q];
      end
    end
  end

  assign xfer = src_valid_i[sel_idx] & src_ready_o[sel_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cur_vc_q    <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      pkt_count_q <= '0;
      error_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          StIdle: begin
            case (sel_flit.flit_label)
              HEAD: begin
                data_q   <= out_flit;
                valid_q  <= 1'b1;
                cur_vc_q <= free_vc;
                owner_q  <= sel_idx;
                grant_q  <= NUM_SRC'(1) << sel_idx;
                state_q  <= StSend;
              end
              HEADTAIL: begin
                data_q      <= out_flit;
                valid_q     <= 1'b1;
                rr_ptr_q    <= wrap_add(sel_idx, 1);
                pkt_count_q <= pkt_count_q + CNT_W'(1);
              end
              default: error_q <= 1'b1;
            endcase
          end
          StSend: begin
            data_q  <= out_flit;
            valid_q <= 1'b1;
            if (sel_flit.flit_label == HEAD || sel_flit.flit_label == HEADTAIL) begin
              error_q <= 1'b1;
            end
            if (sel_flit.flit_label == TAIL) begin
              state_q     <= StIdle;
              grant_q     <= '0;
              rr_ptr_q    <= wrap_add(owner_q, 1);
              pkt_count_q <= pkt_count_q + CNT_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign data_o      = data_q;
  assign is_valid_o  = valid_q;
  assign grant_o     = grant_q;
  assign pkt_count_o = pkt_count_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_local_injection_arbiter.sv
// Directed bench for local_injection_arbiter: reset, round-robin, VC rewrite, backpressure,
// protocol errors, mid-packet reset and counter wrap (DUT built with CNT_W=4).
module tb_local_injection_arbiter;
  import local_injection_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  flit_t       src_data [4];
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  flit_t       data_o;
  logic        is_valid_o;
  logic [1:0]  on_off;
  logic [1:0]  alloc;
  logic [3:0]  grant_o;
  logic [3:0]  pkt_count_o;
  logic        error_o;

  int checks = 0;
  int passed = 0;
  flit_t mon_q[$];

  local_injection_arbiter #(.NUM_SRC(4), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .src_data_i       (src_data),
    .src_valid_i      (src_valid),
    .src_ready_o      (src_ready),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (on_off),
    .is_allocatable_i (alloc),
    .grant_o          (grant_o),
    .pkt_count_o      (pkt_count_o),
    .error_o          (error_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (is_valid_o === 1'b1) mon_q.push_back(data_o);

  function automatic flit_t mk(flit_label_t l, logic vc, logic [31:0] d);
    flit_t f;
    f.flit_label = l;
    f.vcid       = vc;
    f.data       = d;
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; src_valid = 4'b1111; on_off = 2'b11; alloc = 2'b11;
    for (int s = 0; s < 4; s++) src_data[s] = mk(HEAD, 1'b1, 32'h10 + 32'(s));
    cyc(); cyc();
    checks++; if (data_o !== flit_t'(0)) $display("FAIL rst_data: got %h want 0", data_o); else passed++;
    checks++; if (is_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", is_valid_o); else passed++;
    checks++; if (grant_o !== 4'b0) $display("FAIL rst_grant: got %b want 0", grant_o); else passed++;
    checks++; if (pkt_count_o !== 4'd0) $display("FAIL rst_cnt: got %0d want 0", pkt_count_o); else passed++;
    checks++; if (error_o !== 1'b0) $display("FAIL rst_err: got %b want 0", error_o); else passed++;
    checks++; if (src_ready !== 4'b0) $display("FAIL rst_ready: got %b want 0", src_ready); else passed++;
    rst = 1'b1; #1;
    checks++; if (src_ready !== 4'b0001) $display("FAIL first_ready: got %b want 0001", src_ready); else passed++;
    cyc();
    checks++; if (grant_o !== 4'b0001) $display("FAIL first_grant: got %b want 0001", grant_o); else passed++;
    checks++; if (data_o !== mk(HEAD, 1'b0, 32'h10)) $display("FAIL first_head: got %h want %h", data_o, mk(HEAD, 1'b0, 32'h10)); else passed++;
    src_valid = 4'b0001; src_data[0] = mk(TAIL, 1'b1, 32'h1f);
    cyc();
    checks++; if (grant_o !== 4'b0) $display("FAIL first_tail_grant: got %b want 0", grant_o); else passed++;
    checks++; if (pkt_count_o !== 4'd1) $display("FAIL first_cnt: got %0d want 1", pkt_count_o); else passed++;
    src_valid = 4'b0;
    cyc();
    checks++; if (is_valid_o !== 1'b0) $display("FAIL idle_valid: got %b want 0", is_valid_o); else passed++;
    checks++; if (data_o !== mk(TAIL, 1'b0, 32'h1f)) $display("FAIL hold_data: got %h want %h", data_o, mk(TAIL, 1'b0, 32'h1f)); else passed++;
  endtask

  task automatic test_round_robin();
    int pos [4];
    logic [3:0] xfer;
    int exp_src;
    logic [3:0] exp_grant;
    flit_t exp_f;
    rst = 1'b0; src_valid = 4'b0; cyc(); rst = 1'b1;
    for (int s = 0; s < 4; s++) pos[s] = 0;
    src_valid = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      for (int s = 0; s < 4; s++)
        src_data[s] = mk(flit_label_t'(2'(pos[s])), 1'b1, {24'h0, 4'(s), 4'(pos[s])});
      #1; xfer = src_ready & src_valid;
      cyc();
      for (int s = 0; s < 4; s++) if (xfer[s]) pos[s] = (pos[s] == 2) ? 0 : pos[s] + 1;
      exp_src   = (k / 3) % 4;
      exp_grant = (k % 3 == 2) ? 4'b0 : (4'b1 << exp_src);
      exp_f     = mk(flit_label_t'(2'(k % 3)), 1'b0, {24'h0, 4'(exp_src), 4'(k % 3)});
      checks++; if (grant_o !== exp_grant) $display("FAIL rr_grant[%0d]: got %b want %b", k, grant_o, exp_grant); else passed++;
      checks++; if (is_valid_o !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", k, is_valid_o); else passed++;
      checks++; if (data_o !== exp_f) $display("FAIL rr_data[%0d]: got %h want %h", k, data_o, exp_f); else passed++;
    end
    src_valid = 4'b0;
    checks++; if (pkt_count_o !== 4'd5) $display("FAIL rr_cnt: got %0d want 5", pkt_count_o); else passed++;
  endtask

  task automatic test_vc_rewrite();
    alloc = 2'b00; on_off = 2'b11; src_valid = 4'b0100; src_data[2] = mk(HEAD, 1'b0, 32'hA0);
    #1;
    checks++; if (src_ready !== 4'b0) $display("FAIL novc_ready: got %b want 0", src_ready); else passed++;
    cyc();
    checks++; if (is_valid_o !== 1'b0) $display("FAIL novc_valid: got %b want 0", is_valid_o); else passed++;
    alloc = 2'b10; #1;
    checks++; if (src_ready !== 4'b0100) $display("FAIL vc_ready: got %b want 0100", src_ready); else passed++;
    cyc();
    checks++; if (data_o !== mk(HEAD, 1'b1, 32'hA0)) $display("FAIL vc_head: got %h want %h", data_o, mk(HEAD, 1'b1, 32'hA0)); else passed++;
    checks++; if (grant_o !== 4'b0100) $display("FAIL vc_grant: got %b want 0100", grant_o); else passed++;
    alloc = 2'b01; src_data[2] = mk(BODY, 1'b0, 32'hA1);
    cyc();
    checks++; if (data_o !== mk(BODY, 1'b1, 32'hA1)) $display("FAIL vc_body: got %h want %h", data_o, mk(BODY, 1'b1, 32'hA1)); else passed++;
    src_data[2] = mk(TAIL, 1'b0, 32'hA2);
    cyc();
    checks++; if (data_o !== mk(TAIL, 1'b1, 32'hA2)) $display("FAIL vc_tail: got %h want %h", data_o, mk(TAIL, 1'b1, 32'hA2)); else passed++;
    checks++; if (pkt_count_o !== 4'd6) $display("FAIL vc_cnt: got %0d want 6", pkt_count_o); else passed++;
    src_valid = 4'b0; alloc = 2'b11;
  endtask

  task automatic test_backpressure();
    flit_t exp_f [4];
    int idx = 0;
    int cycle = 0;
    logic xfer;
    logic stall;
    cyc();
    mon_q.delete();
    exp_f[0] = mk(HEAD, 1'b1, 32'hB0); exp_f[1] = mk(BODY, 1'b1, 32'hB1);
    exp_f[2] = mk(BODY, 1'b1, 32'hB2); exp_f[3] = mk(TAIL, 1'b1, 32'hB3);
    src_valid = 4'b1000;
    while (idx < 4 && cycle < 20) begin
      src_data[3] = exp_f[idx];
      stall  = (cycle >= 1 && cycle <= 3);
      on_off = stall ? 2'b10 : 2'b11;
      #1; xfer = src_ready[3];
      if (stall) begin
        checks++; if (src_ready[3] !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", cycle, src_ready[3]); else passed++;
      end
      cyc();
      if (xfer) idx++;
      if (stall) begin
        checks++; if (is_valid_o !== 1'b0) $display("FAIL bp_valid[%0d]: got %b want 0", cycle, is_valid_o); else passed++;
        checks++; if (data_o !== mk(HEAD, 1'b0, 32'hB0)) $display("FAIL bp_hold[%0d]: got %h", cycle, data_o); else passed++;
      end
      cycle++;
    end
    checks++; if (idx !== 4) $display("FAIL bp_timeout: got %0d flits want 4", idx); else passed++;
    src_valid = 4'b0; on_off = 2'b11;
    cyc();
    checks++; if (mon_q.size() !== 4) $display("FAIL bp_count: got %0d want 4", mon_q.size()); else passed++;
    for (int i = 0; i < mon_q.size() && i < 4; i++) begin
      checks++;
      if (mon_q[i] !== mk(exp_f[i].flit_label, 1'b0, exp_f[i].data))
        $display("FAIL bp_order[%0d]: got %h want %h", i, mon_q[i], mk(exp_f[i].flit_label, 1'b0, exp_f[i].data));
      else passed++;
    end
    checks++; if (pkt_count_o !== 4'd7) $display("FAIL bp_cnt: got %0d want 7", pkt_count_o); else passed++;
  endtask

  task automatic test_protocol_error();
    src_valid = 4'b0010; src_data[1] = mk(BODY, 1'b0, 32'hC1);
    #1;
    checks++; if (src_ready !== 4'b0010) $display("FAIL err_ready: got %b want 0010", src_ready); else passed++;
    cyc();
    checks++; if (is_valid_o !== 1'b0) $display("FAIL err_drop: got %b want 0", is_valid_o); else passed++;
    checks++; if (error_o !== 1'b1) $display("FAIL err_set: got %b want 1", error_o); else passed++;
    checks++; if (grant_o !== 4'b0) $display("FAIL err_grant: got %b want 0", grant_o); else passed++;
    src_data[1] = mk(HEAD, 1'b0, 32'hC0);
    cyc();
    checks++; if (grant_o !== 4'b0010) $display("FAIL err_regrant: got %b want 0010", grant_o); else passed++;
    checks++; if (data_o !== mk(HEAD, 1'b0, 32'hC0)) $display("FAIL err_head: got %h", data_o); else passed++;
    src_data[1] = mk(TAIL, 1'b0, 32'hC2);
    cyc();
    checks++; if (error_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", error_o); else passed++;
    checks++; if (pkt_count_o !== 4'd8) $display("FAIL err_cnt: got %0d want 8", pkt_count_o); else passed++;
    src_valid = 4'b0;
  endtask

  task automatic test_reset_mid_packet();
    src_valid = 4'b0100; src_data[2] = mk(HEAD, 1'b0, 32'hD0);
    cyc();
    checks++; if (grant_o !== 4'b0100) $display("FAIL mid_grant: got %b want 0100", grant_o); else passed++;
    src_data[2] = mk(BODY, 1'b0, 32'hD1); rst = 1'b0;
    cyc();
    checks++; if (grant_o !== 4'b0) $display("FAIL mid_rst_grant: got %b want 0", grant_o); else passed++;
    checks++; if (is_valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", is_valid_o); else passed++;
    checks++; if (error_o !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", error_o); else passed++;
    checks++; if (pkt_count_o !== 4'd0) $display("FAIL mid_rst_cnt: got %0d want 0", pkt_count_o); else passed++;
    rst = 1'b1; src_valid = 4'b1111;
    for (int s = 0; s < 4; s++) src_data[s] = mk(HEAD, 1'b0, 32'hE0);
    #1;
    checks++; if (src_ready !== 4'b0001) $display("FAIL mid_rr_ptr: got %b want 0001", src_ready); else passed++;
    src_valid = 4'b0;
    cyc();
  endtask

  task automatic test_counter_wrap();
    src_valid = 4'b0001; alloc = 2'b11; on_off = 2'b11;
    for (int n = 1; n <= 17; n++) begin
      src_data[0] = mk(HEADTAIL, 1'b1, 32'(n));
      cyc();
      checks++; if (data_o !== mk(HEADTAIL, 1'b0, 32'(n)) || is_valid_o !== 1'b1) $display("FAIL ht_stream[%0d]: got %h/%b", n, data_o, is_valid_o); else passed++;
      if (n == 15) begin
        checks++; if (pkt_count_o !== 4'd15) $display("FAIL wrap_15: got %0d want 15", pkt_count_o); else passed++;
      end
      if (n == 16) begin
        checks++; if (pkt_count_o !== 4'd0) $display("FAIL wrap_16: got %0d want 0", pkt_count_o); else passed++;
      end
    end
    src_valid = 4'b0;
    checks++; if (pkt_count_o !== 4'd1) $display("FAIL wrap_17: got %0d want 1", pkt_count_o); else passed++;
  endtask

  initial begin
    rst = 1'b0; src_valid = 4'b0; on_off = 2'b11; alloc = 2'b11;
    for (int s = 0; s < 4; s++) src_data[s] = '0;
    test_reset();
    test_round_robin();
    test_vc_rewrite();
    test_backpressure();
    test_protocol_error();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
